// File: rtl/data_mem_arb.sv
// data_mem_arb
//   Data memory for the NRISC multi-core cluster. Every core owns a private
//   bank of 2**LMEM words, and all cores share one further bank of the same
//   size. Private accesses are always accepted. The single-port shared bank
//   accepts at most one access per cycle, picked round-robin (RR_MODE=1) or
//   by fixed priority, where the lowest core index wins (RR_MODE=0).
//
// Ports (all buses are [0:W-1] with bit 0 as the MSB; core i owns slice
// [i*TAM +: TAM] of each packed bus):
//   clk        single clock, every state update happens on posedge
//   rst        synchronous active-high reset
//   dataLoad   per-core read request
//   dataWrite  per-core write request (a write wins if load is also high)
//   dataADDR   per-core address: [0:LMEM-1] word index, [LMEM]=1 selects the shared bank
//   dataIN     per-core write data
//   dataGNT    combinational: the request is accepted at the coming edge
//   dataACK    registered one-cycle pulse marking completion of an accepted access
//   dataOUT    registered read data, held until that core's next completed load
module data_mem_arb #(
    parameter int NCORES  = 2,
    parameter int LMEM    = 8,
    parameter int TAM     = 16,
    parameter int RR_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:NCORES-1]     dataLoad,
    input  logic [0:NCORES-1]     dataWrite,
    input  logic [0:NCORES*TAM-1] dataADDR,
    input  logic [0:NCORES*TAM-1] dataIN,
    output logic [0:NCORES-1]     dataGNT,
    output logic [0:NCORES-1]     dataACK,
    output logic [0:NCORES*TAM-1] dataOUT
);

    localparam int DEPTH = 1 << LMEM;
    localparam int PW    = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [TAM-1:0]    privMem   [NCORES][DEPTH];
    logic [TAM-1:0]    sharedMem [DEPTH];

    logic [0:TAM-1]    coreAddr  [NCORES];
    logic [LMEM-1:0]   coreIdx   [NCORES];
    logic [TAM-1:0]    coreData  [NCORES];
    logic [0:NCORES-1] coreReq;
    logic [0:NCORES-1] coreShared;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     winner;
    logic              sharedValid;
    logic              sharedGnt;
    logic              sharedWrite;
    logic [LMEM-1:0]   sharedIdx;
    logic [TAM-1:0]    sharedData;

    // The address bits above the bank-select bit carry no meaning here.
    logic              unusedAddrBits;
    assign unusedAddrBits = ^dataADDR;

    // Split the packed buses into per-core fields.
    always_comb begin
        coreReq    = '0;
        coreShared = '0;
        for (int i = 0; i < NCORES; i++) begin
            coreAddr[i]   = dataADDR[i*TAM +: TAM];
            coreIdx[i]    = coreAddr[i][0:LMEM-1];
            coreData[i]   = dataIN[i*TAM +: TAM];
            coreReq[i]    = dataLoad[i] | dataWrite[i];
            coreShared[i] = coreAddr[i][LMEM];
        end
    end

    // Shared-bank arbitration. Round-robin runs as two passes: cores from ptr
    // upward first, then the wrap-around part below ptr. Fixed priority uses
    // only the first pass, with no lower bound.
    always_comb begin
        sharedValid = 1'b0;
        winner      = '0;
        sharedIdx   = '0;
        sharedData  = '0;
        sharedWrite = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            if (!sharedValid && coreReq[k] && coreShared[k] &&
                (RR_MODE == 0 || k >= int'(ptr))) begin
                sharedValid = 1'b1;
                winner      = PW'(k);
                sharedIdx   = coreIdx[k];
                sharedData  = coreData[k];
                sharedWrite = dataWrite[k];
            end
        end
        if (RR_MODE != 0) begin
            for (int k = 0; k < NCORES; k++) begin
                if (!sharedValid && coreReq[k] && coreShared[k] && k < int'(ptr)) begin
                    sharedValid = 1'b1;
                    winner      = PW'(k);
                    sharedIdx   = coreIdx[k];
                    sharedData  = coreData[k];
                    sharedWrite = dataWrite[k];
                end
            end
        end
    end

    // Private requests are granted outright. A shared request is granted only
    // to the arbitration winner. Reset masks every grant, so an access
    // presented during reset is dropped.
    always_comb begin
        dataGNT   = '0;
        sharedGnt = sharedValid && !rst;
        for (int i = 0; i < NCORES; i++) begin
            if (!rst && coreReq[i]) begin
                dataGNT[i] = !coreShared[i] || (sharedValid && winner == PW'(i));
            end
        end
    end

    // Bank writes. The banks are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORES; i++) begin
            if (dataGNT[i] && dataWrite[i] && !coreShared[i]) begin
                privMem[i][coreIdx[i]] <= coreData[i];
            end
        end
        if (sharedGnt && sharedWrite) begin
            sharedMem[sharedIdx] <= sharedData;
        end
    end

    // Completion pulses, read data and the round-robin pointer. A granted load
    // returns the bank contents before this edge's writes. This cannot cause a
    // conflict: each bank sees at most one access per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataACK <= '0;
            dataOUT <= '0;
            ptr     <= '0;
        end else begin
            dataACK <= dataGNT;
            for (int i = 0; i < NCORES; i++) begin
                if (dataGNT[i] && !dataWrite[i]) begin
                    dataOUT[i*TAM +: TAM] <= coreShared[i] ? sharedMem[coreIdx[i]]
                                                           : privMem[i][coreIdx[i]];
                end
            end
            if (RR_MODE != 0 && sharedValid) begin
                ptr <= (int'(winner) == NCORES - 1) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arb.sv
// tb_data_mem_arb
//   Drives one round-robin and one fixed-priority instance of data_mem_arb
//   (NCORES=2, LMEM=8, TAM=16) with the same inputs. Hand-computed vectors
//   cover the directed scenarios. A behavioural model of banks, grants and
//   pointer checks both instances on every cycle.
module tb_data_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [0:1]  ld;
    logic [0:1]  wr;
    logic [15:0] a [2];
    logic [15:0] d [2];
    logic [0:31] busAddr;
    logic [0:31] busIn;

    assign busAddr = {a[0], a[1]};
    assign busIn   = {d[0], d[1]};

    logic [0:1]  gntRR, ackRR, gntFP, ackFP;
    logic [0:31] outRR, outFP;

    data_mem_arb #(.NCORES(2), .LMEM(8), .TAM(16), .RR_MODE(1)) dutRR (
        .clk(clk), .rst(rst), .dataLoad(ld), .dataWrite(wr),
        .dataADDR(busAddr), .dataIN(busIn),
        .dataGNT(gntRR), .dataACK(ackRR), .dataOUT(outRR)
    );

    data_mem_arb #(.NCORES(2), .LMEM(8), .TAM(16), .RR_MODE(0)) dutFP (
        .clk(clk), .rst(rst), .dataLoad(ld), .dataWrite(wr),
        .dataADDR(busAddr), .dataIN(busIn),
        .dataGNT(gntFP), .dataACK(ackFP), .dataOUT(outFP)
    );

    typedef struct {
        logic        rst;
        logic [0:1]  ld;
        logic [0:1]  wr;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [0:1]  gntRR;
        logic [0:1]  gntFP;
        logic [0:1]  ackRR;
        logic [15:0] out0;
        logic [15:0] out1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state. Index 0 is the round-robin instance and index 1
    // the fixed-priority one.
    logic [15:0] mPriv   [2][2][256];
    logic [15:0] mShared [2][256];
    int          mPtr    [2];
    logic [0:1]  mAck    [2];
    logic [15:0] mOut    [2][2];
    logic [0:1]  mGnt    [2];
    logic [0:1]  lastGntRR;

    function automatic vec_t mk(input logic r, input logic [0:1] l, input logic [0:1] w,
                                input logic [15:0] a0v, input logic [15:0] a1v,
                                input logic [15:0] d0v, input logic [15:0] d1v,
                                input logic [0:1] gr, input logic [0:1] gf,
                                input logic [0:1] ak, input logic [15:0] o0,
                                input logic [15:0] o1);
        vec_t v;
        v.rst = r;  v.ld = l;  v.wr = w;
        v.a0 = a0v; v.a1 = a1v; v.d0 = d0v; v.d1 = d1v;
        v.gntRR = gr; v.gntFP = gf; v.ackRR = ak; v.out0 = o0; v.out1 = o1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Set the inputs, then let the combinational grants settle well before the edge.
    task automatic applyStimulus(input vec_t v);
        rst  = v.rst;
        ld   = v.ld;
        wr   = v.wr;
        a[0] = v.a0;
        a[1] = v.a1;
        d[0] = v.d0;
        d[1] = v.d1;
        #3;
    endtask

    // Grants from the rules: private requests always win. For the shared bank,
    // the round-robin instance takes the first requester counting from its
    // pointer modulo 2, and the fixed-priority instance takes the lowest index.
    function automatic logic [0:1] modelGrant(input int m);
        logic [0:1] g;
        bit         found;
        int         c;
        g     = 2'b00;
        found = 1'b0;
        if (rst) return 2'b00;
        for (int i = 0; i < 2; i++) begin
            if ((ld[i] || wr[i]) && !a[i][7]) g[i] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            c = (m == 0) ? (mPtr[0] + k) % 2 : k;
            if (!found && (ld[c] || wr[c]) && a[c][7]) begin
                found = 1'b1;
                g[c]  = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic modelCommit();
        int idx;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mAck[m]    = 2'b00;
                mOut[m][0] = 16'h0000;
                mOut[m][1] = 16'h0000;
                mPtr[m]    = 0;
            end else begin
                mAck[m] = mGnt[m];
                for (int c = 0; c < 2; c++) begin
                    if (mGnt[m][c]) begin
                        idx = int'(a[c][15:8]);
                        if (wr[c]) begin
                            if (a[c][7]) mShared[m][idx] = d[c];
                            else         mPriv[m][c][idx] = d[c];
                        end else begin
                            mOut[m][c] = a[c][7] ? mShared[m][idx] : mPriv[m][c][idx];
                        end
                        if (a[c][7] && m == 0) mPtr[0] = (c + 1) % 2;
                    end
                end
            end
        end
    endtask

    // One clock: compare the grants before the edge, advance the model at the
    // edge, then compare completions and read data just after it.
    task automatic runCycle();
        for (int m = 0; m < 2; m++) mGnt[m] = modelGrant(m);
        checkOutput("model gntRR", 32'(gntRR), 32'(mGnt[0]));
        checkOutput("model gntFP", 32'(gntFP), 32'(mGnt[1]));
        lastGntRR = mGnt[0];
        @(posedge clk);
        #1;
        modelCommit();
        checkOutput("model ackRR", 32'(ackRR), 32'(mAck[0]));
        checkOutput("model ackFP", 32'(ackFP), 32'(mAck[1]));
        checkOutput("model outRR", outRR, {mOut[0][0], mOut[0][1]});
        checkOutput("model outFP", outFP, {mOut[1][0], mOut[1][1]});
    endtask

    vec_t tbl [22];

    initial begin
        logic [0:1]  rl, rw;
        logic [15:0] ra [2];
        logic [15:0] rd [2];
        logic [7:0]  idx;
        bit          held;

        mPtr[0] = 0;
        mPtr[1] = 0;
        lastGntRR = 2'b00;

        // Reset with live requests present: no grant, no completion, cleared read data.
        for (int r = 0; r < 2; r++) begin
            applyStimulus(mk(1'b1, 2'b10, 2'b01, 16'h0100, 16'h0280, 16'h0000, 16'h9999,
                             2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000));
            checkOutput("reset gntRR", 32'(gntRR), 32'h0);
            checkOutput("reset gntFP", 32'(gntFP), 32'h0);
            runCycle();
            checkOutput("reset ackRR", 32'(ackRR), 32'h0);
            checkOutput("reset outRR", outRR, 32'h0);
            checkOutput("reset outFP", outFP, 32'h0);
        end

        // Give every index used below a known value: private core c word k holds
        // A000+c*100h+k, and shared word k holds 5000h+k.
        for (int k = 0; k < 17; k++) begin
            idx = (k < 16) ? 8'(k) : 8'hFF;
            applyStimulus(mk(1'b0, 2'b00, 2'b11, {idx, 8'h00}, {idx, 8'h00},
                             16'hA000 + 16'(idx), 16'hA100 + 16'(idx),
                             2'b00, 2'b00, 2'b00, 16'h0, 16'h0));
            runCycle();
        end
        for (int k = 0; k < 17; k++) begin
            idx = (k < 16) ? 8'(k) : 8'hFF;
            applyStimulus(mk(1'b0, 2'b00, 2'b10, {idx, 8'h80}, 16'h0000,
                             16'h5000 + 16'(idx), 16'h0000,
                             2'b00, 2'b00, 2'b00, 16'h0, 16'h0));
            runCycle();
        end

        // The last init grant went to core 0, so the round-robin pointer now sits at 1.
        //              rst   ld     wr     a0        a1        d0        d1        gRR    gFP    ackRR  out0      out1
        tbl[0]  = mk(1'b0, 2'b01, 2'b00, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 2'b01, 2'b01, 2'b01, 16'h0000, 16'h5000);
        tbl[1]  = mk(1'b0, 2'b00, 2'b10, 16'h0500, 16'h0000, 16'hBEEF, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h0000, 16'h5000);
        tbl[2]  = mk(1'b0, 2'b11, 2'b00, 16'h0500, 16'h0500, 16'h0000, 16'h0000, 2'b11, 2'b11, 2'b11, 16'hBEEF, 16'hA105);
        tbl[3]  = mk(1'b0, 2'b00, 2'b11, 16'h0580, 16'h0580, 16'h1111, 16'h2222, 2'b10, 2'b10, 2'b10, 16'hBEEF, 16'hA105);
        tbl[4]  = mk(1'b0, 2'b00, 2'b01, 16'h0000, 16'h0580, 16'h0000, 16'h2222, 2'b01, 2'b01, 2'b01, 16'hBEEF, 16'hA105);
        tbl[5]  = mk(1'b0, 2'b11, 2'b00, 16'h0380, 16'h0380, 16'h0000, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h5003, 16'hA105);
        tbl[6]  = mk(1'b0, 2'b11, 2'b00, 16'h0380, 16'h0380, 16'h0000, 16'h0000, 2'b01, 2'b10, 2'b01, 16'h5003, 16'h5003);
        tbl[7]  = mk(1'b0, 2'b11, 2'b00, 16'h0380, 16'h0380, 16'h0000, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h5003, 16'h5003);
        tbl[8]  = mk(1'b0, 2'b11, 2'b00, 16'h0380, 16'h0380, 16'h0000, 16'h0000, 2'b01, 2'b10, 2'b01, 16'h5003, 16'h5003);
        tbl[9]  = mk(1'b0, 2'b11, 2'b00, 16'h0380, 16'h0380, 16'h0000, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h5003, 16'h5003);
        tbl[10] = mk(1'b0, 2'b11, 2'b00, 16'h0380, 16'h0380, 16'h0000, 16'h0000, 2'b01, 2'b10, 2'b01, 16'h5003, 16'h5003);
        tbl[11] = mk(1'b0, 2'b10, 2'b00, 16'h0580, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h2222, 16'h5003);
        tbl[12] = mk(1'b0, 2'b10, 2'b01, 16'h0700, 16'h0B80, 16'h0000, 16'h1234, 2'b11, 2'b11, 2'b11, 16'hA007, 16'h5003);
        tbl[13] = mk(1'b0, 2'b10, 2'b00, 16'h0B80, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h1234, 16'h5003);
        tbl[14] = mk(1'b1, 2'b00, 2'b10, 16'h0A80, 16'h0000, 16'h7777, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000);
        tbl[15] = mk(1'b0, 2'b11, 2'b00, 16'h0A80, 16'h0A80, 16'h0000, 16'h0000, 2'b10, 2'b10, 2'b10, 16'h500A, 16'h0000);
        tbl[16] = mk(1'b0, 2'b01, 2'b00, 16'h0000, 16'h0A80, 16'h0000, 16'h0000, 2'b01, 2'b01, 2'b01, 16'h500A, 16'h500A);
        tbl[17] = mk(1'b0, 2'b01, 2'b01, 16'h0000, 16'h0380, 16'h0000, 16'h00FF, 2'b01, 2'b01, 2'b01, 16'h500A, 16'h500A);
        tbl[18] = mk(1'b0, 2'b01, 2'b00, 16'h0000, 16'h0380, 16'h0000, 16'h0000, 2'b01, 2'b01, 2'b01, 16'h500A, 16'h00FF);
        tbl[19] = mk(1'b0, 2'b00, 2'b11, 16'hFF00, 16'hFF80, 16'hCAFE, 16'hF00D, 2'b11, 2'b11, 2'b11, 16'h500A, 16'h00FF);
        tbl[20] = mk(1'b0, 2'b11, 2'b00, 16'hFF7F, 16'hFF80, 16'h0000, 16'h0000, 2'b11, 2'b11, 2'b11, 16'hCAFE, 16'hF00D);
        tbl[21] = mk(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'hCAFE, 16'hF00D);

        for (int r = 0; r < 22; r++) begin
            applyStimulus(tbl[r]);
            checkOutput($sformatf("row%0d gntRR", r), 32'(gntRR), 32'(tbl[r].gntRR));
            checkOutput($sformatf("row%0d gntFP", r), 32'(gntFP), 32'(tbl[r].gntFP));
            runCycle();
            checkOutput($sformatf("row%0d ackRR", r), 32'(ackRR), 32'(tbl[r].ackRR));
            checkOutput($sformatf("row%0d outRR", r), outRR, {tbl[r].out0, tbl[r].out1});
        end

        // Shared write by core 0, then core 1 reads the same word on the next cycle.
        applyStimulus(mk(1'b0, 2'b00, 2'b10, 16'h0680, 16'h0000, 16'hABCD, 16'h0000,
                         2'b10, 2'b10, 2'b10, 16'hCAFE, 16'hF00D));
        checkOutput("hazard wr gntRR", 32'(gntRR), 32'(2'b10));
        runCycle();
        applyStimulus(mk(1'b0, 2'b01, 2'b00, 16'h0000, 16'h0680, 16'h0000, 16'h0000,
                         2'b01, 2'b01, 2'b01, 16'hCAFE, 16'hABCD));
        checkOutput("hazard rd gntRR", 32'(gntRR), 32'(2'b01));
        runCycle();
        checkOutput("hazard rd ackRR", 32'(ackRR), 32'(2'b01));
        checkOutput("hazard rd outRR", outRR, {16'hCAFE, 16'hABCD});

        // Random traffic on the initialised indices, with random ignored address
        // bits. A core whose shared request the round-robin instance refused keeps
        // its request unchanged.
        rl = 2'b00;
        rw = 2'b00;
        ra[0] = 16'h0; ra[1] = 16'h0; rd[0] = 16'h0; rd[1] = 16'h0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                held = (rl[c] || rw[c]) && ra[c][7] && !lastGntRR[c];
                if (!held) begin
                    rl[c] = 1'($urandom_range(0, 1));
                    rw[c] = 1'($urandom_range(0, 2) == 0);
                    idx   = ($urandom_range(0, 16) == 16) ? 8'hFF : 8'($urandom_range(0, 15));
                    ra[c] = {idx, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127))};
                    rd[c] = 16'($urandom);
                end
            end
            applyStimulus(mk(1'($urandom_range(0, 24) == 0), rl, rw, ra[0], ra[1], rd[0], rd[1],
                             2'b00, 2'b00, 2'b00, 16'h0, 16'h0));
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
